// File: rtl/nios_cpu_oc_mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port on-chip memory between two Avalon-MM masters.
// One grant per cycle; m1 is forced through after STARVE_LIMIT waiting cycles; reads return 1 cycle later.
module nios_cpu_oc_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       r_rd_vld;
    logic       r_rd_owner;
    logic [7:0] r_starve_cnt;

    logic w_req0;
    logic w_req1;
    logic w_force_m1;
    logic w_grant0;
    logic w_grant1;
    logic w_rd_accept;

    // Requests are masked during reset so nothing reaches the memory and both masters stall.
    assign w_req0     = reset_n & (m0_read | m0_write);
    assign w_req1     = reset_n & (m1_read | m1_write);
    assign w_force_m1 = (r_starve_cnt == LIMIT) & w_req1;
    assign w_grant1   = w_req1 & (~w_req0 | w_force_m1);
    assign w_grant0   = w_req0 & ~w_grant1;

    assign m0_waitrequest = ~w_grant0;
    assign m1_waitrequest = ~w_grant1;

    // A simultaneous read+write is a write; it produces no read response.
    assign w_rd_accept = (w_grant0 & m0_read & ~m0_write) |
                         (w_grant1 & m1_read & ~m1_write);

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (w_grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
            mem_writedata  = m0_writedata;
        end else if (w_grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_clken = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_vld     <= 1'b0;
            r_rd_owner   <= 1'b0;
            r_starve_cnt <= 8'd0;
        end else begin
            r_rd_vld <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_owner <= w_grant1;
            end
            if (w_req1 & ~w_grant1) begin
                if (r_starve_cnt != LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end
            end else begin
                r_starve_cnt <= 8'd0;
            end
        end
    end

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

    // Gated by reset_n so a read accepted just before reset is never delivered.
    assign m0_readdatavalid = reset_n & r_rd_vld & ~r_rd_owner;
    assign m1_readdatavalid = reset_n & r_rd_vld &  r_rd_owner;

endmodule

// File: tb/tb_nios_cpu_oc_mem_arbiter.sv
// Bench for nios_cpu_oc_mem_arbiter: directed scenarios plus randomized traffic against a
// reference model tracking memory contents, m1 wait time and the expected read responses.
module tb_nios_cpu_oc_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;

    logic [31:0] mem     [4096] = '{default: '0};
    logic [31:0] ref_mem [4096] = '{default: '0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_cpu_oc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Single-port synchronous RAM: write lands on the edge, read data appears after the edge.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic idle_all();
        set_m0(0, 0, 12'h0, 4'h0, 32'h0);
        set_m1(0, 0, 12'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_m0(1, 0, 12'h001, 4'hF, 32'h0);
        set_m1(0, 1, 12'h002, 4'hF, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
                errors++; $display("FAIL reset_wait: got %b expected 11", {m0_waitrequest, m1_waitrequest});
            end
            checks++;
            if ({mem_chipselect, m0_readdatavalid, m1_readdatavalid} !== 3'b000) begin
                errors++; $display("FAIL reset_outputs: got %b expected 000",
                                   {mem_chipselect, m0_readdatavalid, m1_readdatavalid});
            end
            tick();
        end
        idle_all();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken} !== 4'b1101) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 1101",
                               {m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken});
        end
        tick();
    endtask

    task automatic test_write_read();
        set_m0(0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, mem_chipselect, mem_write, mem_address} !== {3'b011, 12'h010}) begin
            errors++; $display("FAIL wr_accept: got %b_%h expected 011_010",
                               {m0_waitrequest, mem_chipselect, mem_write}, mem_address);
        end
        tick();
        set_m0(1, 0, 12'h010, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, mem_write, m0_readdatavalid} !== 3'b000) begin
            errors++; $display("FAIL rd_accept: got %b expected 000", {m0_waitrequest, mem_write, m0_readdatavalid});
        end
        tick();
        idle_all();
        @(negedge clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_return: got vld=%b data=%h expected vld=10 data=deadbeef",
                               {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
        end
        tick();
    endtask

    task automatic test_byteenable();
        set_m1(0, 1, 12'h0FF, 4'hF, 32'hAAAAAAAA);
        tick();
        set_m1(0, 1, 12'h0FF, 4'h3, 32'h12345678);
        tick();
        set_m1(1, 0, 12'h0FF, 4'hF, 32'h0);
        tick();
        idle_all();
        @(negedge clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'hAAAA5678) begin
            errors++; $display("FAIL byteenable: got vld=%b data=%h expected vld=01 data=aaaa5678",
                               {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
        end
        tick();
    endtask

    task automatic test_collision();
        set_m0(0, 1, 12'h020, 4'hF, 32'h00000001);
        set_m1(1, 0, 12'h020, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL collide_grant: got %b expected 01", {m0_waitrequest, m1_waitrequest});
        end
        tick();
        set_m0(0, 0, 12'h0, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin
            errors++; $display("FAIL collide_m1_next: got %b expected 10", {m0_waitrequest, m1_waitrequest});
        end
        tick();
        idle_all();
        @(negedge clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'h00000001) begin
            errors++; $display("FAIL collide_data: got vld=%b data=%h expected vld=01 data=00000001",
                               {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
        end
        tick();
    endtask

    // m0 holds 0xDEADBEEF at 0x010 and m1 reads 0xAAAA5678 at 0x0FF, so the data identifies the owner.
    task automatic test_starvation();
        logic prev_vld = 1'b0;
        logic prev_m1  = 1'b0;
        logic exp_m1;
        logic [31:0] exp_d;
        for (int k = 0; k < 28; k++) begin
            if (k < 27) begin
                set_m0(1, 0, 12'h010, 4'hF, 32'h0);
                set_m1(1, 0, 12'h0FF, 4'hF, 32'h0);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (k < 27) begin
                exp_m1 = (k % 9) == 8;
                checks++;
                if ({m0_waitrequest, m1_waitrequest} !== {exp_m1, ~exp_m1}) begin
                    errors++; $display("FAIL starve_grant[%0d]: got %b expected %b", k,
                                       {m0_waitrequest, m1_waitrequest}, {exp_m1, ~exp_m1});
                end
            end
            if (prev_vld) begin
                exp_d = prev_m1 ? 32'hAAAA5678 : 32'hDEADBEEF;
                checks++;
                if ({m0_readdatavalid, m1_readdatavalid} !== {~prev_m1, prev_m1} || m0_readdata !== exp_d) begin
                    errors++; $display("FAIL starve_resp[%0d]: got vld=%b data=%h expected vld=%b data=%h", k,
                                       {m0_readdatavalid, m1_readdatavalid}, m0_readdata, {~prev_m1, prev_m1}, exp_d);
                end
            end
            prev_vld = (k < 27);
            prev_m1  = exp_m1;
            tick();
        end
    endtask

    task automatic test_reset_inflight();
        set_m1(1, 0, 12'h0FF, 4'hF, 32'h0);
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0) begin
            errors++; $display("FAIL inflight_accept: got %b expected 0", m1_waitrequest);
        end
        tick();
        reset_n = 1'b0;
        set_m0(1, 0, 12'h010, 4'hF, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
                errors++; $display("FAIL inflight_reset[%0d]: got %b expected 0011", i,
                                   {m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest});
            end
            tick();
        end
        reset_n = 1'b1;
        // Counter restarts from zero: m1 waits exactly LIMIT cycles again.
        for (int k = 0; k <= LIMIT; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_waitrequest, m1_waitrequest} !== ((k == LIMIT) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL post_reset_grant[%0d]: got %b expected %b", k,
                                   {m0_waitrequest, m1_waitrequest}, (k == LIMIT) ? 2'b10 : 2'b01);
            end
            if (k == 0) begin
                checks++;
                if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
                    errors++; $display("FAIL post_reset_vld: got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
                end
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_read_write_both();
        set_m0(1, 1, 12'h030, 4'hF, 32'h0000_0055);
        @(negedge clk);
        checks++;
        if ({m0_waitrequest, mem_write, mem_writedata} !== {2'b01, 32'h55}) begin
            errors++; $display("FAIL rw_both_write: got %b_%h expected 01_00000055",
                               {m0_waitrequest, mem_write}, mem_writedata);
        end
        tick();
        idle_all();
        @(negedge clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            errors++; $display("FAIL rw_both_novld: got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
        end
        tick();
        set_m0(1, 0, 12'h030, 4'hF, 32'h0);
        tick();
        idle_all();
        @(negedge clk);
        checks++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h55) begin
            errors++; $display("FAIL rw_both_data: got vld=%b data=%h expected vld=1 data=00000055",
                               m0_readdatavalid, m0_readdata);
        end
        tick();
    endtask

    // Random traffic in 0x200..0x21F: model tracks contents, how long m1 has waited, and the pending response.
    task automatic test_random();
        int m1_wait = 0;
        logic pv0 = 0, pv1 = 0;
        logic [31:0] pd = '0;
        int op0, op1;
        logic req0, req1, g0, g1;
        logic [11:0] a;
        logic [3:0] be;
        logic [31:0] d;
        logic is_wr, is_rd;
        for (int k = 0; k < 400; k++) begin
            op0 = (k < 399) ? $urandom_range(0, 3) : 0;
            op1 = (k < 399) ? $urandom_range(0, 3) : 0;
            set_m0(op0[0], op0[1], 12'h200 + 12'($urandom_range(0, 31)), 4'($urandom), $urandom);
            set_m1(op1[0], op1[1], 12'h200 + 12'($urandom_range(0, 31)), 4'($urandom), $urandom);
            req0 = op0 != 0;
            req1 = op1 != 0;
            g1 = req1 && (!req0 || m1_wait >= LIMIT);
            g0 = req0 && !g1;
            @(negedge clk);
            checks++;
            if ({m0_waitrequest, m1_waitrequest, mem_chipselect} !== {~g0, ~g1, g0 | g1}) begin
                errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", k,
                                   {m0_waitrequest, m1_waitrequest, mem_chipselect}, {~g0, ~g1, g0 | g1});
            end
            checks++;
            if ({m0_readdatavalid, m1_readdatavalid} !== {pv0, pv1} || ((pv0 || pv1) && m0_readdata !== pd)) begin
                errors++; $display("FAIL rand_resp[%0d]: got vld=%b data=%h expected vld=%b data=%h", k,
                                   {m0_readdatavalid, m1_readdatavalid}, m0_readdata, {pv0, pv1}, pd);
            end
            a     = g1 ? m1_address : m0_address;
            be    = g1 ? m1_byteenable : m0_byteenable;
            d     = g1 ? m1_writedata : m0_writedata;
            is_wr = g1 ? m1_write : (g0 && m0_write);
            is_rd = (g0 || g1) && !is_wr;
            pv0 = g0 && is_rd;
            pv1 = g1 && is_rd;
            if (is_rd) pd = ref_mem[a];
            if (is_wr)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            m1_wait = (req1 && !g1) ? ((m1_wait < LIMIT) ? m1_wait + 1 : LIMIT) : 0;
            tick();
        end
        idle_all();
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        tick();
        test_reset();
        test_write_read();
        test_byteenable();
        test_collision();
        test_starvation();
        test_reset_inflight();
        test_read_write_both();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
